// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/LSU request ports and shared memory port of the arbiter
interface mem_arbiter_if;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;

  logic        i_ls_req;
  logic        i_ls_we;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic [3:0]  i_ls_bmask;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [31:0] o_ls_rdata;

  logic        o_mem_en;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic [31:0] i_mem_rdata;

  logic        o_stall;

  modport slave (
    input  i_if_req, i_if_addr, i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_bmask, i_mem_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask, o_stall
  );

  modport master (
    output i_if_req, i_if_addr, i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_bmask, i_mem_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask, o_stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/LSU) arbiter for one memory port with starvation guard
module mem_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  mem_arbiter_if.slave  io_bus
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [2:0] LAT_INIT   = 3'(RD_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     r_state;
  logic [2:0] r_lat_cnt;
  logic [3:0] r_starve_cnt;
  logic       r_owner_ls;

  logic w_idle;
  logic w_if_win;
  logic w_ls_win;
  logic w_rd_done;

  // Grants are decided combinationally from the current requests; reset masks them.
  assign w_idle    = (r_state == IDLE) && !i_reset;
  assign w_if_win  = w_idle && io_bus.i_if_req &&
                     (!io_bus.i_ls_req || (r_starve_cnt == STARVE_LIM));
  assign w_ls_win  = w_idle && io_bus.i_ls_req && !w_if_win;
  assign w_rd_done = (r_state == RD_WAIT) && (r_lat_cnt == 3'd0) && !i_reset;

  assign io_bus.o_if_gnt    = w_if_win;
  assign io_bus.o_ls_gnt    = w_ls_win;

  assign io_bus.o_mem_en    = w_if_win || w_ls_win;
  assign io_bus.o_mem_we    = w_ls_win && io_bus.i_ls_we;
  assign io_bus.o_mem_addr  = w_ls_win ? io_bus.i_ls_addr : io_bus.i_if_addr;
  assign io_bus.o_mem_wdata = io_bus.i_ls_wdata;
  assign io_bus.o_mem_bmask = w_ls_win ? io_bus.i_ls_bmask : 4'hF;

  assign io_bus.o_if_rvalid = w_rd_done && !r_owner_ls;
  assign io_bus.o_ls_rvalid = w_rd_done && r_owner_ls;
  assign io_bus.o_if_rdata  = io_bus.i_mem_rdata;
  assign io_bus.o_ls_rdata  = io_bus.i_mem_rdata;

  assign io_bus.o_stall = !i_reset &&
                          ((io_bus.i_if_req && !w_if_win) ||
                           (io_bus.i_ls_req && !w_ls_win) ||
                           (r_state == RD_WAIT));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_lat_cnt    <= 3'd0;
      r_starve_cnt <= 4'd0;
      r_owner_ls   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // LSU writes finish in the grant cycle, so only reads occupy the port.
          if (w_if_win || (w_ls_win && !io_bus.i_ls_we)) begin
            r_state    <= RD_WAIT;
            r_lat_cnt  <= LAT_INIT;
            r_owner_ls <= w_ls_win;
          end
        end
        RD_WAIT: begin
          if (r_lat_cnt == 3'd0) begin
            r_state <= IDLE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (!io_bus.i_if_req || w_if_win) begin
        r_starve_cnt <= 4'd0;
      end else if (r_starve_cnt != STARVE_LIM) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter at RD_LAT 1, 3 and 2
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_bmask = '0;
  logic [31:0] mem_rdata = '0;

  wire [2:0]  if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, stall;
  wire [31:0] if_rdata [3];
  wire [31:0] ls_rdata [3];
  wire [31:0] mem_addr [3];
  wire [31:0] mem_wdata [3];
  wire [3:0]  mem_bmask [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus [3] ();

  // Instance 0: RD_LAT=1, instance 1: RD_LAT=3, instance 2: RD_LAT=2.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    assign bus[g].i_if_req    = if_req;
    assign bus[g].i_if_addr   = if_addr;
    assign bus[g].i_ls_req    = ls_req;
    assign bus[g].i_ls_we     = ls_we;
    assign bus[g].i_ls_addr   = ls_addr;
    assign bus[g].i_ls_wdata  = ls_wdata;
    assign bus[g].i_ls_bmask  = ls_bmask;
    assign bus[g].i_mem_rdata = mem_rdata;
    assign if_gnt[g]    = bus[g].o_if_gnt;
    assign if_rvalid[g] = bus[g].o_if_rvalid;
    assign if_rdata[g]  = bus[g].o_if_rdata;
    assign ls_gnt[g]    = bus[g].o_ls_gnt;
    assign ls_rvalid[g] = bus[g].o_ls_rvalid;
    assign ls_rdata[g]  = bus[g].o_ls_rdata;
    assign mem_en[g]    = bus[g].o_mem_en;
    assign mem_we[g]    = bus[g].o_mem_we;
    assign mem_addr[g]  = bus[g].o_mem_addr;
    assign mem_wdata[g] = bus[g].o_mem_wdata;
    assign mem_bmask[g] = bus[g].o_mem_bmask;
    assign stall[g]     = bus[g].o_stall;

    mem_arbiter #(.RD_LAT(LAT), .STARVE_MAX(4)) u_dut (
      .i_clk   (clk),
      .i_reset (rst),
      .io_bus  (bus[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    if_req = 1'b0;
    ls_req = 1'b0;
    ls_we  = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({if_gnt[d], ls_gnt[d], mem_en[d], mem_we[d], stall[d], if_rvalid[d], ls_rvalid[d]} !== 7'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got gnt=%b%b en=%b we=%b stall=%b rv=%b%b, want all 0", d,
                 if_gnt[d], ls_gnt[d], mem_en[d], mem_we[d], stall[d], if_rvalid[d], ls_rvalid[d]);
      end
    end
    tick();
    rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_en[0], stall[0], if_rvalid[0], ls_rvalid[0]} !== 4'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got en=%b stall=%b rv=%b%b, want 0", mem_en[0], stall[0], if_rvalid[0], ls_rvalid[0]);
    end
    drain();
  endtask

  task automatic test_fetch_read();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    @(negedge clk);
    checks++;
    if ({if_gnt[0], ls_gnt[0], mem_en[0], mem_we[0], stall[0]} !== 5'b10100 ||
        mem_addr[0] !== 32'h0000_0010 || mem_bmask[0] !== 4'hF) begin
      errors++;
      $display("FAIL fetch_grant: got gnt=%b en=%b we=%b stall=%b addr=%h bm=%h, want gnt=1 en=1 we=0 stall=0 addr=00000010 bm=f",
               if_gnt[0], mem_en[0], mem_we[0], stall[0], mem_addr[0], mem_bmask[0]);
    end
    tick();
    if_req = 1'b0; mem_rdata = 32'hCAFE_0010;
    @(negedge clk);
    checks++;
    if ({if_rvalid[0], mem_en[0], stall[0]} !== 3'b001) begin
      errors++;
      $display("FAIL fetch_wait: got rv=%b en=%b stall=%b, want rv=0 en=0 stall=1", if_rvalid[0], mem_en[0], stall[0]);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({if_rvalid[0], ls_rvalid[0]} !== 2'b10 || if_rdata[0] !== 32'hCAFE_0010) begin
      errors++;
      $display("FAIL fetch_rvalid: got if_rv=%b ls_rv=%b data=%h, want 1 0 cafe0010", if_rvalid[0], ls_rvalid[0], if_rdata[0]);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({if_rvalid[0], stall[0]} !== 2'b00) begin
      errors++;
      $display("FAIL fetch_done: got rv=%b stall=%b, want 0 0", if_rvalid[0], stall[0]);
    end
    drain();
  endtask

  task automatic test_contention();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0200;
    @(negedge clk);
    checks++;
    if ({ls_gnt[0], if_gnt[0], mem_we[0], stall[0]} !== 4'b1001 || mem_addr[0] !== 32'h0000_0200) begin
      errors++;
      $display("FAIL contend_ls_first: got ls=%b if=%b we=%b stall=%b addr=%h, want 1 0 0 1 00000200",
               ls_gnt[0], if_gnt[0], mem_we[0], stall[0], mem_addr[0]);
    end
    tick();
    ls_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_gnt[0], stall[0]} !== 2'b01) begin
      errors++;
      $display("FAIL contend_wait: got if_gnt=%b stall=%b, want 0 1", if_gnt[0], stall[0]);
    end
    tick();
    mem_rdata = 32'h5A5A_0200;
    @(negedge clk);
    checks++;
    if ({ls_rvalid[0], if_gnt[0], stall[0]} !== 3'b101 || ls_rdata[0] !== 32'h5A5A_0200) begin
      errors++;
      $display("FAIL contend_ls_rvalid: got rv=%b if_gnt=%b stall=%b data=%h, want 1 0 1 5a5a0200",
               ls_rvalid[0], if_gnt[0], stall[0], ls_rdata[0]);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({if_gnt[0], ls_rvalid[0], stall[0]} !== 3'b100 || mem_addr[0] !== 32'h0000_0040) begin
      errors++;
      $display("FAIL contend_fetch_grant: got gnt=%b rv=%b stall=%b addr=%h, want 1 0 0 00000040",
               if_gnt[0], ls_rvalid[0], stall[0], mem_addr[0]);
    end
    drain();
  endtask

  task automatic test_starvation();
    logic [9:0] e_ls = 10'b0110001111;
    logic [9:0] e_if = 10'b1000010000;
    logic [9:0] e_rv = 10'b0001000000;
    if_req = 1'b1; if_addr = 32'h0000_0080;
    ls_req = 1'b1; ls_we = 1'b1; ls_bmask = 4'h3;
    mem_rdata = 32'hF00D_0080;
    for (int c = 0; c < 10; c++) begin
      ls_addr  = 32'h0000_0300 + 32'(c);
      ls_wdata = 32'h0000_1000 + 32'(c);
      @(negedge clk);
      checks++;
      if ({if_gnt[0], ls_gnt[0], mem_en[0], mem_we[0], if_rvalid[0], stall[0]} !==
          {e_if[c], e_ls[c], e_if[c] | e_ls[c], e_ls[c], e_rv[c], 1'b1}) begin
        errors++;
        $display("FAIL starve_c%0d: got if=%b ls=%b en=%b we=%b rv=%b stall=%b, want if=%b ls=%b we=%b rv=%b stall=1",
                 c, if_gnt[0], ls_gnt[0], mem_en[0], mem_we[0], if_rvalid[0], stall[0], e_if[c], e_ls[c], e_ls[c], e_rv[c]);
      end
      if (e_ls[c]) begin
        checks++;
        if (mem_addr[0] !== ls_addr || mem_wdata[0] !== ls_wdata || mem_bmask[0] !== 4'h3) begin
          errors++;
          $display("FAIL starve_wr_c%0d: got addr=%h wd=%h bm=%h, want %h %h 3", c, mem_addr[0], mem_wdata[0], mem_bmask[0], ls_addr, ls_wdata);
        end
      end
      if (e_rv[c]) begin
        checks++;
        if (if_rdata[0] !== 32'hF00D_0080) begin
          errors++;
          $display("FAIL starve_rdata: got %h, want f00d0080", if_rdata[0]);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    ls_req = 1'b1; ls_we = 1'b1;
    for (int c = 0; c < 3; c++) begin
      ls_addr  = 32'h0000_0700 + 32'(4 * c);
      ls_wdata = 32'hA000_0000 + 32'(c);
      ls_bmask = 4'(1 << c);
      @(negedge clk);
      checks++;
      if ({ls_gnt[0], mem_en[0], mem_we[0], stall[0], ls_rvalid[0]} !== 5'b11100 ||
          mem_addr[0] !== ls_addr || mem_wdata[0] !== ls_wdata || mem_bmask[0] !== ls_bmask) begin
        errors++;
        $display("FAIL b2b_write_%0d: got gnt=%b en=%b we=%b stall=%b rv=%b addr=%h wd=%h bm=%h, want 1 1 1 0 0 %h %h %h",
                 c, ls_gnt[0], mem_en[0], mem_we[0], stall[0], ls_rvalid[0], mem_addr[0], mem_wdata[0], mem_bmask[0],
                 ls_addr, ls_wdata, ls_bmask);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_lat3();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0400;
    mem_rdata = 32'h3333_0400;
    @(negedge clk);
    checks++;
    if (ls_gnt[1] !== 1'b1) begin
      errors++;
      $display("FAIL lat3_grant: got %b, want 1", ls_gnt[1]);
    end
    tick();
    ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0500;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if ({if_gnt[1], ls_gnt[1], mem_en[1], ls_rvalid[1]} !== {3'b000, c == 4}) begin
        errors++;
        $display("FAIL lat3_c%0d: got gnt=%b%b en=%b rv=%b, want gnt=00 en=0 rv=%b", c, if_gnt[1], ls_gnt[1], mem_en[1], ls_rvalid[1], c == 4);
      end
      if (c == 4) begin
        checks++;
        if (ls_rdata[1] !== 32'h3333_0400) begin
          errors++;
          $display("FAIL lat3_rdata: got %h, want 33330400", ls_rdata[1]);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({if_gnt[1], mem_addr[1]} !== {1'b1, 32'h0000_0500}) begin
      errors++;
      $display("FAIL lat3_next_grant: got gnt=%b addr=%h, want 1 00000500", if_gnt[1], mem_addr[1]);
    end
    drain();
  endtask

  task automatic test_reset_mid_read();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0600;
    @(negedge clk);
    checks++;
    if (ls_gnt[2] !== 1'b1) begin
      errors++;
      $display("FAIL rst_read_grant: got %b, want 1", ls_gnt[2]);
    end
    tick();
    ls_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ls_rvalid[2], stall[2], mem_en[2]} !== 3'b000) begin
      errors++;
      $display("FAIL rst_during_read: got rv=%b stall=%b en=%b, want 0 0 0", ls_rvalid[2], stall[2], mem_en[2]);
    end
    tick();
    rst = 1'b0;
    for (int c = 2; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({ls_rvalid[2], if_rvalid[2], stall[2]} !== 3'b000) begin
        errors++;
        $display("FAIL rst_discard_c%0d: got rv=%b%b stall=%b, want 000", c, ls_rvalid[2], if_rvalid[2], stall[2]);
      end
      tick();
    end
    if_req = 1'b1; if_addr = 32'h0000_0610;
    @(negedge clk);
    checks++;
    if ({if_gnt[2], mem_en[2], stall[2]} !== 3'b110) begin
      errors++;
      $display("FAIL rst_next_grant: got gnt=%b en=%b stall=%b, want 1 1 0", if_gnt[2], mem_en[2], stall[2]);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_contention();
    test_starvation();
    test_back_to_back();
    test_lat3();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
